instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_LOG2, default 10, word-address width of the internal instruction store (1024 x 32 bits).
REQ-002 SHALL provide parameter RESET_VECTOR, default 32'hBFC00000, byte address mapped to word 0.
REQ-003 SHALL provide parameter WAIT_CYCLES, default 2, wait states inserted per fetch when INSTR_MEM_WAIT_EN is defined; legal range 1..15.
REQ-004 SHALL provide ports in this order:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr_address  input  32  fetch byte address from the CPU control path.
- instr_read  input  1  fetch request.
- instr_waitrequest  output  1  high while an accepted or pending fetch is not yet complete.
- instr_readdata  output  32  fetched instruction word; valid only in the cycle where instr_read=1 and instr_waitrequest=0.
- addr_error  output  1  one-cycle pulse, coincident with completion, for a misaligned or out-of-range fetch.
- load_en  input  1  store write enable (program loader).
- load_addr  input  DEPTH_LOG2  store word index.
- load_data  input  32  store write data.

Function
REQ-005 SHALL implement states IDLE, WAIT and RESP.
REQ-006 In IDLE, instr_read=1 SHALL accept the request, latch instr_address and move to WAIT (macro defined) or RESP (macro undefined).
REQ-007 Later changes to instr_address during WAIT/RESP SHALL be ignored; only the latched address is used.
REQ-008 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded with WAIT_CYCLES-1 on acceptance, then SHALL move to RESP.
REQ-009 instr_readdata SHALL be registered on entry to RESP from store[(latched_addr - RESET_VECTOR) >> 2].
REQ-010 instr_waitrequest SHALL be 1 when instr_read=1 and state!=RESP, and 0 otherwise.
REQ-011 RESP SHALL last one cycle, then return to IDLE; back-to-back fetches SHALL therefore be separated by one IDLE cycle.
REQ-012 Fetch latency, acceptance to completion, SHALL be WAIT_CYCLES+1 cycles with the macro defined and 1 cycle without it.
REQ-013 Address arithmetic SHALL be modulo 2^32.
REQ-014 A fetch SHALL be out-of-range when the word offset is >= 2^DEPTH_LOG2, and misaligned when latched_addr[1:0]!=0.
REQ-015 For an out-of-range or misaligned fetch, instr_readdata SHALL be 32'h0 (MIPS nop) and addr_error SHALL pulse in the RESP cycle.
REQ-016 A load_en write SHALL take effect at the clock edge in any state.
REQ-017 If a load write and the RESP-entry read target the same word in the same cycle, the new load_data SHALL be returned (write-first).
REQ-018 If instr_read drops during WAIT, the fetch SHALL complete internally and return to IDLE; its data SHALL be discarded and addr_error SHALL still pulse if applicable.

Reset
REQ-019 While reset=0: state=IDLE, wait counter=0, instr_readdata=0, addr_error=0, and the latched address SHALL equal RESET_VECTOR.
REQ-020 instr_waitrequest SHALL follow REQ-010 during reset (1 if instr_read=1).
REQ-021 Store contents SHALL NOT be cleared by reset.
REQ-022 Reset asserted mid-fetch SHALL abort the fetch with no completion and no addr_error pulse.
REQ-023 The first fetch after reset release SHALL be accepted on the first rising edge with reset=1.

Configuration
REQ-024 Macro INSTR_MEM_WAIT_EN defined: the WAIT state and counter SHALL be present and fetch latency SHALL be WAIT_CYCLES+1.
REQ-025 Macro INSTR_MEM_WAIT_EN undefined: the WAIT state and counter SHALL be omitted, WAIT_CYCLES SHALL be ignored, and latency SHALL be 1 cycle.

Verification
REQ-026 Load word 0 = 32'h2408000A; hold instr_read=1 with instr_address=32'hBFC00000 -> macro on: waitrequest high 3 cycles, readdata 32'h2408000A in cycle 4; macro off: valid in cycle 2.
REQ-027 Fetch 32'hBFC00002 -> readdata 32'h0 with a one-cycle addr_error pulse in the completion cycle.
REQ-028 Fetch 32'hBFC01000 (offset 1024) -> readdata 0 with addr_error; fetch 32'hBFC00FFC -> word 1023 returned with no error.
REQ-029 Drive reset low during WAIT -> waitrequest follows REQ-010, no completion and no addr_error; after release, a fetch of 32'hBFC00000 returns store data intact.
REQ-030 Load word 5 = 32'hDEADBEEF in the RESP-entry cycle of a fetch to 32'hBFC00014 -> readdata 32'hDEADBEEF.
REQ-031 Change instr_address during WAIT -> data returned is from the originally latched address.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: a word store behind a CPU fetch handshake with optional wait states.
// Build macro INSTR_MEM_WAIT_EN enables the WAIT state and its wait-state counter.
module instr_mem_responder #(
   parameter int unsigned DEPTH_LOG2   = 10,
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter int unsigned WAIT_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           instr_address,
   input  logic                  instr_read,
   output logic                  instr_waitrequest,
   output logic [31:0]           instr_readdata,
   output logic                  addr_error,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [31:0]           load_data
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

`ifdef INSTR_MEM_WAIT_EN
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
   logic [3:0] cnt_q, cnt_d;
`else
   typedef enum logic [1:0] {S_IDLE, S_RESP} state_e;
   logic unused_wait_cycles;
   assign unused_wait_cycles = ^WAIT_CYCLES;
`endif

   state_e                state_q, state_d;
   logic [31:0]           addr_q, addr_d;
   logic [31:0]           rdata_q;
   logic                  err_q;
   logic [31:0]           mem_q [DEPTH];

   logic [31:0]           rd_addr;
   logic [31:0]           rd_off;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  rd_bad;
   logic                  enter_resp;

   // Entry from IDLE reads the address being latched this edge; entry from WAIT uses the latch.
   assign rd_addr    = (state_q == S_IDLE) ? instr_address : addr_q;
   assign rd_off     = rd_addr - RESET_VECTOR;
   assign rd_idx     = rd_off[DEPTH_LOG2+1:2];
   assign rd_bad     = (|rd_addr[1:0]) || (|(rd_off >> (DEPTH_LOG2 + 2)));
   assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
`ifdef INSTR_MEM_WAIT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (instr_read) begin
               addr_d  = instr_address;
`ifdef INSTR_MEM_WAIT_EN
               state_d = S_WAIT;
               cnt_d   = WAIT_LOAD;
`else
               state_d = S_RESP;
`endif
            end
         end
`ifdef INSTR_MEM_WAIT_EN
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         addr_q  <= RESET_VECTOR;
`ifdef INSTR_MEM_WAIT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
`ifdef INSTR_MEM_WAIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Store is deliberately outside the reset domain so program contents survive reset.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem_q[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         if (rd_bad) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end else begin
            // Write-first when the loader hits the word being fetched on the same edge.
            rdata_q <= (load_en && (load_addr == rd_idx)) ? load_data : mem_q[rd_idx];
            err_q   <= 1'b0;
         end
      end else begin
         err_q <= 1'b0;
      end
   end

   assign instr_waitrequest = instr_read && (state_q != S_RESP);
   assign instr_readdata    = rdata_q;
   assign addr_error        = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder; expected latency follows INSTR_MEM_WAIT_EN.
module tb_instr_mem_responder;

   localparam int unsigned DEPTH_LOG2 = 10;
   localparam int unsigned DEPTH      = 1024;
   localparam logic [31:0] RV         = 32'hBFC00000;
   localparam int unsigned W          = 2;
`ifdef INSTR_MEM_WAIT_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr_address = '0;
   logic        instr_read = 1'b0;
   logic        instr_waitrequest;
   logic [31:0] instr_readdata;
   logic        addr_error;
   logic        load_en = 1'b0;
   logic [9:0]  load_addr = '0;
   logic [31:0] load_data = '0;

   logic [31:0] shadow [DEPTH];
   int unsigned tests = 0;
   int unsigned fails = 0;

   always #5 clk = ~clk;

   instr_mem_responder #(
      .DEPTH_LOG2  (DEPTH_LOG2),
      .RESET_VECTOR(RV),
      .WAIT_CYCLES (W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .instr_address    (instr_address),
      .instr_read       (instr_read),
      .instr_waitrequest(instr_waitrequest),
      .instr_readdata   (instr_readdata),
      .addr_error       (addr_error),
      .load_en          (load_en),
      .load_addr        (load_addr),
      .load_data        (load_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // {addr_error, readdata} a fetch of byte address a should produce.
   function automatic logic [32:0] expect_fetch(input logic [31:0] a);
      logic [31:0] off;
      logic [31:0] w;
      off = a - RV;
      w   = off >> 2;
      if (a[1:0] != 2'b00 || w >= DEPTH) return {1'b1, 32'h0};
      return {1'b0, shadow[w[9:0]]};
   endfunction

   task automatic load_word(input logic [9:0] idx, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = idx;
      load_data = d;
      shadow[idx] = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic fetch(input logic [31:0] a, input bit scramble, input bit drop,
                        input bit do_load, input logic [9:0] ld_idx, input logic [31:0] ld_data);
      logic [32:0] e;
      bit done;
      instr_address = a;
      instr_read    = 1'b1;
      if (do_load && LAT == 1) begin
         load_en = 1'b1; load_addr = ld_idx; load_data = ld_data; shadow[ld_idx] = ld_data;
      end
      #1 check("wr_on_accept", {31'b0, instr_waitrequest}, 32'd1);
      done = 1'b0;
      for (int k = 1; k <= LAT + 4 && !done; k++) begin
         @(negedge clk);
         load_en = 1'b0;
         e = expect_fetch(a);
         if (!drop || k == 1) begin
            if (instr_waitrequest === 1'b0) begin
               check("latency", 32'(k), 32'(LAT));
               check("rdata", instr_readdata, e[31:0]);
               check("err", {31'b0, addr_error}, {31'b0, e[32]});
               done = 1'b1;
            end else begin
               check("err_while_wait", {31'b0, addr_error}, 32'd0);
            end
         end else begin
            check("drop_wr", {31'b0, instr_waitrequest}, 32'd0);
            check("drop_err", {31'b0, addr_error}, (k == LAT) ? {31'b0, e[32]} : 32'd0);
            if (k == LAT) done = 1'b1;
         end
         if (!done) begin
            if (do_load && k == LAT - 1) begin
               load_en = 1'b1; load_addr = ld_idx; load_data = ld_data; shadow[ld_idx] = ld_data;
            end
            if (scramble && k == 1) instr_address = ~a;
            if (drop && k == 1) instr_read = 1'b0;
         end
      end
      check("completed", {31'b0, done}, 32'd1);
      instr_read = 1'b0;
      @(negedge clk);
      check("err_one_cycle", {31'b0, addr_error}, 32'd0);
      check("wr_after", {31'b0, instr_waitrequest}, 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] w;
      logic [9:0]  li;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_rdata", instr_readdata, 32'h0);
      check("rst_err", {31'b0, addr_error}, 32'd0);
      check("rst_wr_idle", {31'b0, instr_waitrequest}, 32'd0);
      instr_read = 1'b1;
      #1 check("rst_wr_read", {31'b0, instr_waitrequest}, 32'd1);
      instr_read = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      for (int unsigned i = 0; i < DEPTH; i++) begin
         load_word(10'(i), (i == 0) ? 32'h2408000A : $urandom());
      end

      fetch(RV, 0, 0, 0, '0, '0);
      fetch(RV + 32'h2, 0, 0, 0, '0, '0);
      fetch(RV + 32'h1000, 0, 0, 0, '0, '0);
      fetch(RV + 32'hFFC, 0, 0, 0, '0, '0);
      fetch(RV - 32'h4, 0, 0, 0, '0, '0);
      fetch(RV + 32'h14, 0, 0, 1, 10'd5, 32'hDEADBEEF);
      fetch(RV + 32'h40, 1, 0, 0, '0, '0);
      fetch(RV + 32'h1, 0, 1, 0, '0, '0);
      fetch(RV + 32'h8, 0, 1, 0, '0, '0);

      // Reset mid-fetch: no completion, no error, store preserved.
      instr_address = RV;
      instr_read    = 1'b1;
`ifdef INSTR_MEM_WAIT_EN
      @(negedge clk);
`endif
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rstmid_wr", {31'b0, instr_waitrequest}, 32'd1);
         check("rstmid_err", {31'b0, addr_error}, 32'd0);
         check("rstmid_rdata", instr_readdata, 32'h0);
         @(negedge clk);
      end
      reset = 1'b1;
      instr_read = 1'b0;
      fetch(RV, 0, 0, 0, '0, '0);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0, 1:    a = RV + ($urandom_range(0, 1023) << 2);
            2:       a = RV + ($urandom_range(0, 1023) << 2) + $urandom_range(1, 3);
            default: a = $urandom();
         endcase
         w  = (a - RV) >> 2;
         li = ($urandom_range(0, 1) == 0) ? w[9:0] : 10'($urandom_range(0, 1023));
         fetch(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 2) == 0), li, $urandom());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
